// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage with an on-chip instruction memory. A byte-serial
// loader fills the memory while the core is frozen. When run is enabled, the
// stage presents the instruction at the current PC to IF/ID. Fetch halts
// permanently, until reset, when it reaches the HALT_WORD encoding.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset (memory contents survive)
//   i_en             run enable: 1 = fetch/advance, 0 = frozen, loader allowed
//   i_stall          hazard stall, holds the PC
//   i_branch         taken branch/jump redirect (wins over i_stall)
//   i_branch_target  redirect address
//   i_ld_valid       loader byte strobe (accepted only while i_en = 0)
//   i_ld_byte        loader byte, little-endian within a word
//   o_instr          instruction at the current PC (combinational read)
//   o_pc             current PC
//   o_pc_next        o_pc + 4
//   o_halt           high while fetch is halted
//   o_ld_words       number of complete words written by the loader
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                  NB_INSTR   = 32,
    parameter int                  NB_PC      = 32,
    parameter int                  IMEM_DEPTH = 256,
    parameter logic [NB_INSTR-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_stall,
    input  logic                i_branch,
    input  logic [NB_PC-1:0]    i_branch_target,
    input  logic                i_ld_valid,
    input  logic [7:0]          i_ld_byte,
    output logic [NB_INSTR-1:0] o_instr,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_PC-1:0]    o_pc_next,
    output logic                o_halt,
    output logic [NB_PC-1:0]    o_ld_words
);

    localparam int NB_ADDR = $clog2(IMEM_DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NB_PC-1:0]     pc;
    logic [NB_PC-1:0]     pc_d;
    logic [NB_INSTR-1:0]  mem [IMEM_DEPTH];
    logic [NB_ADDR-1:0]   rd_idx;
    logic                 is_halt_word;

    // Loader state: bytes 0..2 are collected in asm_reg, and byte 3 goes
    // straight into the written word. A partial word never reaches memory.
    logic [1:0]           byte_cnt;
    logic [NB_ADDR-1:0]   wr_ptr;
    logic [23:0]          asm_reg;
    logic [NB_PC-1:0]     ld_words;
    logic                 ld_accept;
    logic                 ld_commit;
    logic [31:0]          ld_word;

    // ---------------------------------------------------------------------
    // Memory: combinational read, single write port owned by the loader.
    // The read index ignores the byte-offset bits and the PC bits above the
    // memory size, so addresses wrap modulo the depth.
    // ---------------------------------------------------------------------
    assign rd_idx       = pc[NB_ADDR+1:2];
    assign o_instr      = mem[rd_idx];
    assign is_halt_word = (o_instr == HALT_WORD);

    // These PC bits do not take part in the memory index.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[NB_PC-1:NB_ADDR+2], pc[1:0]};

    assign ld_accept = i_ld_valid & ~i_en;
    assign ld_commit = ld_accept & (byte_cnt == 2'd3);
    assign ld_word   = {i_ld_byte, asm_reg};

    // NOTE: the memory has no reset, so a loaded program survives reset,
    // and the array can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (ld_commit && !i_rst) begin
            mem[wr_ptr] <= NB_INSTR'(ld_word);
        end
    end

    // ---------------------------------------------------------------------
    // Loader byte assembly, word pointer and word counter
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values, whatever the order of the blocks.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            byte_cnt <= 2'd0;
            wr_ptr   <= '0;
            asm_reg  <= '0;
            ld_words <= '0;
        end else if (ld_accept) begin
            case (byte_cnt)
                2'd0:    asm_reg[7:0]   <= i_ld_byte;
                2'd1:    asm_reg[15:8]  <= i_ld_byte;
                2'd2:    asm_reg[23:16] <= i_ld_byte;
                default: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    ld_words <= ld_words + 1'b1;
                end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign o_ld_words = ld_words;

    // ---------------------------------------------------------------------
    // Fetch FSM: state register / next-state logic / output logic
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (state == ST_RUN && i_en && !i_branch && is_halt_word) begin
            state_next = ST_HALT;
        end
    end

    // o_halt comes straight from the state flop. It rises on the edge after
    // the halt word is seen and drops with reset.
    always_comb begin
        o_halt = (state == ST_HALT);
    end

    // ---------------------------------------------------------------------
    // Program counter. A redirect wins over a stall. A halt word freezes the
    // PC on the same edge that moves the FSM to HALT.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_d = pc;
        if (state == ST_RUN && i_en) begin
            if (i_branch) begin
                pc_d = i_branch_target;
            end else if (!i_stall && !is_halt_word) begin
                pc_d = pc + NB_PC'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc <= '0;
        end else begin
            pc <= pc_d;
        end
    end

    assign o_pc      = pc;
    assign o_pc_next = pc + NB_PC'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch with a small memory (16 words), so that
// address wrap and loader wrap are reached quickly. Expected fetch results come
// from a bench-side memory model. They are queued as each step is driven, then
// popped and compared once the step has taken effect.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int NB_INSTR = 32;
    localparam int NB_PC    = 32;
    localparam int DEPTH    = 16;

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_en;
    logic                i_stall;
    logic                i_branch;
    logic [NB_PC-1:0]    i_branch_target;
    logic                i_ld_valid;
    logic [7:0]          i_ld_byte;
    logic [NB_INSTR-1:0] o_instr;
    logic [NB_PC-1:0]    o_pc;
    logic [NB_PC-1:0]    o_pc_next;
    logic                o_halt;
    logic [NB_PC-1:0]    o_ld_words;

    always #5 clk = ~clk;

    instr_fetch #(
        .NB_INSTR   (NB_INSTR),
        .NB_PC      (NB_PC),
        .IMEM_DEPTH (DEPTH),
        .HALT_WORD  (32'hFFFF_FFFF)
    ) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_en            (i_en),
        .i_stall         (i_stall),
        .i_branch        (i_branch),
        .i_branch_target (i_branch_target),
        .i_ld_valid      (i_ld_valid),
        .i_ld_byte       (i_ld_byte),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .o_pc_next       (o_pc_next),
        .o_halt          (o_halt),
        .o_ld_words      (o_ld_words)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_exp_t;

    fetch_exp_t  sb[$];
    logic [31:0] mem_model [DEPTH];
    int          ld_ptr   = 0;
    logic [31:0] ld_count = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One rising edge. Outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_ld_valid = 1'b1;
        i_ld_byte  = b;
        tick();
        i_ld_valid = 1'b0;
    endtask

    // Loads one word little-endian and records it in the model.
    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
        mem_model[ld_ptr] = w;
        ld_ptr   = (ld_ptr + 1) % DEPTH;
        ld_count = ld_count + 1;
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] pc);
        fetch_exp_t e;
        e.tag   = tag;
        e.pc    = pc;
        e.instr = mem_model[(pc >> 2) % DEPTH];
        sb.push_back(e);
    endtask

    task automatic compare_fetch();
        fetch_exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_pc"},      o_pc,      e.pc);
            check({e.tag, "_pc_next"}, o_pc_next, e.pc + 32'd4);
            check({e.tag, "_instr"},   o_instr,   e.instr);
        end
    endtask

    task automatic do_reset();
        i_en       = 1'b0;
        i_stall    = 1'b0;
        i_branch   = 1'b0;
        i_ld_valid = 1'b0;
        i_rst      = 1'b1;
        tick();
        i_rst    = 1'b0;
        ld_ptr   = 0;
        ld_count = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst           = 1'b0;
        i_en            = 1'b0;
        i_stall         = 1'b0;
        i_branch        = 1'b0;
        i_branch_target = '0;
        i_ld_valid      = 1'b0;
        i_ld_byte       = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_pc",       o_pc,          32'd0);
        check("rst_pc_next",  o_pc_next,     32'd4);
        check("rst_halt",     {31'd0, o_halt}, 32'd0);
        check("rst_ld_words", o_ld_words,    32'd0);

        // Load: the first word is visible at PC 0 right after its write edge
        send_word(32'h0050_0013);
        expect_fetch("load_w0", 32'd0);
        compare_fetch();
        send_byte(8'hEF);
        send_byte(8'hBE);
        check("partial_ld_words", o_ld_words, 32'd1);
        send_byte(8'hAD);
        send_byte(8'hDE);
        mem_model[ld_ptr] = 32'hDEAD_BEEF;
        ld_ptr   = ld_ptr + 1;
        ld_count = ld_count + 1;
        check("load2_ld_words", o_ld_words, ld_count);
        send_word(32'h1234_5678);
        send_word(32'h0000_0033);
        check("load4_ld_words", o_ld_words, ld_count);

        // Sequential fetch
        i_en = 1'b1;
        expect_fetch("seq0", 32'd0);
        compare_fetch();
        for (int k = 1; k <= 3; k++) begin
            expect_fetch($sformatf("seq%0d", k), 32'(4 * k));
            tick();
            compare_fetch();
        end

        // Stall holds, then redirect wins over stall, then frozen hold
        i_stall = 1'b1;
        expect_fetch("stall", 32'd12);
        tick();
        compare_fetch();
        i_branch        = 1'b1;
        i_branch_target = 32'h40;
        expect_fetch("stall_branch", 32'h40);
        tick();
        compare_fetch();
        i_en            = 1'b0;
        i_branch_target = 32'h8;
        expect_fetch("frozen_branch", 32'h40);
        tick();
        compare_fetch();
        i_branch = 1'b0;
        i_stall  = 1'b0;

        // Halt: reload with a halt word at index 2 and run from 0
        do_reset();
        send_word(32'h0050_0013);
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        check("halt_ld_words", o_ld_words, 32'd3);
        i_en = 1'b1;
        expect_fetch("halt_run0", 32'd0);
        compare_fetch();
        expect_fetch("halt_run1", 32'd4);
        tick();
        compare_fetch();
        expect_fetch("halt_run2", 32'd8);
        tick();
        compare_fetch();
        check("halt_not_yet", {31'd0, o_halt}, 32'd0);
        tick();
        check("halt_set", {31'd0, o_halt}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            i_branch        = (k == 3 || k == 4);
            i_branch_target = 32'h20;
            i_stall         = (k == 5);
            i_en            = (k != 7);
            expect_fetch($sformatf("halted%0d", k), 32'd8);
            tick();
            compare_fetch();
            check($sformatf("halted%0d_flag", k), {31'd0, o_halt}, 32'd1);
        end
        do_reset();
        check("halt_rst_pc",   o_pc, 32'd0);
        check("halt_rst_flag", {31'd0, o_halt}, 32'd0);

        // Loader bytes offered while running are dropped
        i_en    = 1'b1;
        i_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hAA);
        end
        check("drop_ld_words", o_ld_words, 32'd0);
        check("drop_pc",       o_pc,       32'd0);
        i_en    = 1'b0;
        i_stall = 1'b0;

        // Loader wrap: DEPTH+1 words, the last overwrites index 0
        for (int i = 0; i <= DEPTH; i++) begin
            send_word(32'hA000_0000 + 32'(i));
        end
        check("wrap_ld_words", o_ld_words, 32'(DEPTH + 1));
        i_en            = 1'b1;
        i_branch        = 1'b1;
        i_branch_target = 32'(4 * DEPTH);
        expect_fetch("wrap_pc_depth", 32'(4 * DEPTH));
        tick();
        compare_fetch();
        i_branch_target = 32'hFFFF_FFFC;
        expect_fetch("wrap_pc_top", 32'hFFFF_FFFC);
        tick();
        compare_fetch();
        i_branch = 1'b0;
        expect_fetch("wrap_pc_zero", 32'd0);
        tick();
        compare_fetch();
        i_en = 1'b0;

        // Reset mid-load: the partial word and a same-edge byte are discarded
        send_byte(8'h11);
        send_byte(8'h22);
        i_ld_valid = 1'b1;
        i_ld_byte  = 8'h99;
        i_rst      = 1'b1;
        tick();
        i_rst      = 1'b0;
        i_ld_valid = 1'b0;
        ld_ptr     = 0;
        ld_count   = '0;
        send_word(32'h1122_3344);
        check("midrst_ld_words", o_ld_words, 32'd1);
        expect_fetch("midrst_w0", 32'd0);
        compare_fetch();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
